store_cntrl_1: RTL and testbench

- Write-side counterpart of the fetch controller: accepts store requests (address, data, byte mask) on a vld/rdy interface and writes them into port A of a ram_block_sdp data RAM.
- Returns one write response per accepted request on a downstream vld/rdy interface through a small response FIFO.
- Keeps a running count of committed writes for the bench and debug.

---
 rtl/store_cntrl_1.sv | 133 +++++++++++++
 tb/tb_store_cntrl_1.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/store_cntrl_1.sv
// Store controller: accepts masked store requests, writes them into port A of a
// simple dual-port RAM and returns one in-order response per request through a small FIFO.
// Optional macro STORE_CNTRL_PROP_RDY_EN lets a response pop free a slot for a
// request in the same cycle (combinational s1_rdy -> s0_rdy path).

module ram_block_sdp #(
    parameter int A_S = 8,
    parameter int D_S = 32,
    parameter int M_S = 4
) (
    input  logic           clk,
    input  logic [M_S-1:0] wea,
    input  logic [A_S-1:0] addra,
    input  logic [D_S-1:0] dina,
    input  logic           reb,
    input  logic [A_S-1:0] addrb,
    output logic [D_S-1:0] doutb
);
    localparam int L_S = D_S / M_S;

    logic [D_S-1:0] mem [2**A_S];

    always_ff @(posedge clk) begin
        for (int i = 0; i < M_S; i++) begin
            if (wea[i]) begin
                mem[addra][i*L_S +: L_S] <= dina[i*L_S +: L_S];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reb) begin
            doutb <= mem[addrb];
        end
    end
endmodule

module store_cntrl_1 #(
    parameter int A_S       = 8,
    parameter int D_S       = 32,
    parameter int M_S       = 4,
    parameter int RSP_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s0_vld,
    input  logic [A_S-1:0] s0_addr,
    input  logic [D_S-1:0] s0_data,
    input  logic [M_S-1:0] s0_be,
    output logic           s0_rdy,
    output logic           s1_vld,
    output logic [A_S-1:0] s1_addr,
    output logic           s1_err,
    input  logic           s1_rdy,
    output logic [15:0]    wr_cnt
);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [PW-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic [A_S-1:0] rsp_addr_reg [RSP_DEPTH];
    logic           rsp_err_reg  [RSP_DEPTH];
    logic [15:0]    wr_cnt_reg;
    logic           rsp_full, s0_trans, s1_trans, mask_zero;
    logic [M_S-1:0] wea;
    logic [D_S-1:0] ram_doutb_unused;

    assign rsp_full = (count_reg == CW'(RSP_DEPTH));

`ifdef STORE_CNTRL_PROP_RDY_EN
    // A pop in a full cycle frees the slot the incoming request lands in.
    assign s0_rdy = (~rsp_full | s1_rdy) & ~rst;
`else
    assign s0_rdy = ~rsp_full & ~rst;
`endif

    assign s0_trans  = s0_vld & s0_rdy & ~rst;
    assign mask_zero = ~|s0_be;
    assign s1_vld    = (count_reg != '0);
    assign s1_trans  = s1_vld & s1_rdy;
    assign s1_addr   = rsp_addr_reg[rd_ptr_reg];
    assign s1_err    = rsp_err_reg[rd_ptr_reg];
    assign wr_cnt    = wr_cnt_reg;
    assign wea       = s0_trans ? s0_be : '0;

    ram_block_sdp #(.A_S(A_S), .D_S(D_S), .M_S(M_S)) u_ram (
        .clk   (clk),
        .wea   (wea),
        .addra (s0_addr),
        .dina  (s0_data),
        .reb   (1'b0),
        .addrb ('0),
        .doutb (ram_doutb_unused)
    );

    // Entries are cleared on reset so s1_addr/s1_err read zero out of reset.
    for (genvar gi = 0; gi < RSP_DEPTH; gi++) begin : g_rsp
        always_ff @(posedge clk) begin
            if (rst) begin
                rsp_addr_reg[gi] <= '0;
                rsp_err_reg[gi]  <= 1'b0;
            end else if (s0_trans && wr_ptr_reg == PW'(gi)) begin
                rsp_addr_reg[gi] <= s0_addr;
                rsp_err_reg[gi]  <= mask_zero;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            wr_cnt_reg <= '0;
        end else begin
            if (s0_trans) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (s1_trans) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({s0_trans, s1_trans})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            if (s0_trans && !mask_zero) begin
                wr_cnt_reg <= wr_cnt_reg + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_store_cntrl_1.sv
// Bench for store_cntrl_1: directed steps then random traffic, checked against a
// queue/array reference model of the request/response/RAM behaviour.
module tb_store_cntrl_1;
    localparam int DEPTH = 2;
`ifdef STORE_CNTRL_PROP_RDY_EN
    localparam bit PROP = 1'b1;
`else
    localparam bit PROP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_vld, s0_rdy, s1_vld, s1_err, s1_rdy;
    logic [7:0]  s0_addr, s1_addr;
    logic [31:0] s0_data;
    logic [3:0]  s0_be;
    logic [15:0] wr_cnt;

    int total = 0;
    int bad   = 0;

    logic [8:0]  rsp_q [$];
    logic [31:0] mem_m [256];
    logic [3:0]  known [256];
    logic [15:0] cnt_m;

    always #5 clk = ~clk;

    store_cntrl_1 #(.A_S(8), .D_S(32), .M_S(4), .RSP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s0_vld(s0_vld), .s0_addr(s0_addr), .s0_data(s0_data), .s0_be(s0_be), .s0_rdy(s0_rdy),
        .s1_vld(s1_vld), .s1_addr(s1_addr), .s1_err(s1_err), .s1_rdy(s1_rdy),
        .wr_cnt(wr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ram_chk(input logic [7:0] a);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{known[a][i]}};
        if (m != 0) chk($sformatf("ram[%0h]", a), dut.u_ram.mem[a] & m, mem_m[a] & m);
    endtask

    // One clock cycle: drive, check outputs against the model, advance the model.
    task automatic cyc(input logic vld, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic rdy, output logic acc);
        logic exp_rdy, pop;
        logic [8:0] e;
        s0_vld = vld; s0_addr = a; s0_data = d; s0_be = be; s1_rdy = rdy;
        #1;
        exp_rdy = !rst && (rsp_q.size() < DEPTH || (PROP && rdy && rsp_q.size() > 0));
        chk("s0_rdy", 32'(s0_rdy), 32'(exp_rdy));
        chk("s1_vld", 32'(s1_vld), 32'(rsp_q.size() != 0));
        if (rsp_q.size() != 0) begin
            chk("s1_addr", 32'(s1_addr), 32'(rsp_q[0][8:1]));
            chk("s1_err", 32'(s1_err), 32'(rsp_q[0][0]));
        end
        chk("wr_cnt", 32'(wr_cnt), 32'(cnt_m));
        acc = vld && exp_rdy;
        pop = rdy && rsp_q.size() != 0;
        @(posedge clk);
        if (rst) begin
            rsp_q.delete();
            cnt_m = 16'd0;
        end else begin
            if (pop) begin
                e = rsp_q.pop_front();
                $display("rsp addr=%02h err=%0d", e[8:1], e[0]);
            end
            if (acc) begin
                rsp_q.push_back({a, be == 4'd0});
                if (be != 4'd0) begin
                    for (int i = 0; i < 4; i++) begin
                        if (be[i]) begin
                            mem_m[a][i*8 +: 8] = d[i*8 +: 8];
                            known[a][i] = 1'b1;
                        end
                    end
                    cnt_m = cnt_m + 16'd1;
                end
                $display("req addr=%02h data=%08h be=%h", a, d, be);
            end
        end
        #1;
        ram_chk(a);
    endtask

    initial begin
        logic acc;
        int n;
        for (int i = 0; i < 256; i++) begin mem_m[i] = '0; known[i] = '0; end
        cnt_m = 16'd0;
        rst = 1'b1; s0_vld = 0; s0_addr = 0; s0_data = 0; s0_be = 0; s1_rdy = 0;
        @(posedge clk); #1;
        cyc(1, 8'h44, 32'h0, 4'hF, 0, acc);
        rst = 1'b0;
        chk("rst_s1_addr", 32'(s1_addr), 32'h0);
        chk("rst_s1_err", 32'(s1_err), 32'h0);
        chk("rst_wr_cnt", 32'(wr_cnt), 32'h0);

        // Single full store
        cyc(1, 8'h05, 32'hDEAD_BEEF, 4'hF, 1, acc);
        cyc(0, 8'h00, 32'h0, 4'h0, 1, acc);
        chk("single_ram", dut.u_ram.mem[5], 32'hDEAD_BEEF);
        chk("single_cnt", 32'(wr_cnt), 32'd1);

        // Partial mask over a preloaded word
        cyc(1, 8'h03, 32'h1111_1111, 4'hF, 1, acc);
        cyc(1, 8'h03, 32'hAABB_CCDD, 4'b0101, 1, acc);
        chk("partial_ram", dut.u_ram.mem[3], 32'h11BB_11DD);

        // Zero mask: response with err, no write
        cyc(1, 8'h10, 32'h1234_5678, 4'hF, 1, acc);
        cyc(1, 8'h10, 32'hFFFF_FFFF, 4'h0, 1, acc);
        cyc(0, 8'h00, 32'h0, 4'h0, 0, acc);
        chk("mask0_ram", dut.u_ram.mem[16], 32'h1234_5678);
        chk("mask0_err", 32'(s1_err), 32'd1);
        cyc(0, 8'h00, 32'h0, 4'h0, 1, acc);
        cyc(0, 8'h00, 32'h0, 4'h0, 1, acc);

        // Backpressure: third request stalls until responses drain
        cyc(1, 8'h01, 32'hA1, 4'hF, 0, acc);
        cyc(1, 8'h02, 32'hA2, 4'hF, 0, acc);
        cyc(1, 8'h03, 32'hA3, 4'hF, 0, acc);
        chk("bp_stall", 32'(s0_rdy), 32'd0);
        n = 0;
        do begin
            cyc(1, 8'h03, 32'hA3, 4'hF, 1, acc);
            n++;
        end while (!acc && n < 10);
        chk("bp_accept_bound", 32'(acc), 32'd1);
        repeat (4) cyc(0, 8'h00, 32'h0, 4'h0, 1, acc);

        // Full FIFO with simultaneous pop and new request
        cyc(1, 8'h20, 32'hB0, 4'hF, 0, acc);
        cyc(1, 8'h21, 32'hB1, 4'hF, 0, acc);
        cyc(1, 8'h22, 32'hB2, 4'hF, 1, acc);
        cyc(0, 8'h00, 32'h0, 4'h0, 0, acc);
        repeat (4) cyc(0, 8'h00, 32'h0, 4'h0, 1, acc);

        // Reset with two responses pending; request during reset must not write
        cyc(1, 8'h30, 32'hC0, 4'hF, 0, acc);
        cyc(1, 8'h31, 32'hC1, 4'hF, 0, acc);
        rst = 1'b1;
        cyc(1, 8'h30, 32'hDEAD_0000, 4'hF, 1, acc);
        rst = 1'b0;
        chk("rst_mid_vld", 32'(s1_vld), 32'd0);
        chk("rst_mid_cnt", 32'(wr_cnt), 32'd0);
        chk("rst_mid_ram", dut.u_ram.mem[8'h31], 32'hC1);
        cyc(0, 8'h00, 32'h0, 4'h0, 1, acc);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            cyc($urandom_range(0, 3) != 0, 8'($urandom_range(0, 63)), $urandom,
                ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom), $urandom_range(0, 2) != 0, acc);
        end
        rst = 1'b0;
        repeat (4) cyc(0, 8'h00, 32'h0, 4'h0, 1, acc);
        for (int i = 0; i < 256; i++) ram_chk(8'(i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
